// File: rtl/answer_judge_pkg.sv
// Shared encodings for the answer judge: controller states, result codes, prime table.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package answer_judge_pkg;

  // Product/compare width; 23^3 = 12167 fits in 14 bits.
  localparam int PW_DEFAULT = 14;

  // Controller state encodings observed on STATE.
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;
  localparam logic [3:0] ST_DRAW     = 4'b0110;
  localparam logic [3:0] ST_GOOD     = 4'b1000;
  localparam logic [3:0] ST_OUCH     = 4'b1001;
  localparam logic [3:0] ST_WIN      = 4'b1010;
  localparam logic [3:0] ST_LOSE     = 4'b1011;

  // States that wipe RESULT and abort any judgement in flight.
  localparam int N_CLR = 5;
  localparam logic [N_CLR-1:0][3:0] CLR_STATES = {ST_DRAW, ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE};

  // RESULT encodings.
  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_CORRECT = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  // Judge FSM states.
  typedef enum logic [2:0] {
    J_IDLE = 3'd0,
    J_WAIT = 3'd1,
    J_LOAD = 3'd2,
    J_MUL1 = 3'd3,
    J_MUL2 = 3'd4,
    J_MUL3 = 3'd5,
    J_CMP  = 3'd6
  } judge_state_t;

  // Factor code to prime. Code 0 is a blank slot and contributes 1 to the product.
  // Invalid codes also map to 1; they are flagged separately and never judged correct.
  function automatic logic [4:0] code_to_prime(input logic [3:0] code);
    logic [4:0] p;
    case (code)
      4'd0:    p = 5'd1;
      4'd1:    p = 5'd2;
      4'd2:    p = 5'd3;
      4'd3:    p = 5'd5;
      4'd4:    p = 5'd7;
      4'd5:    p = 5'd11;
      4'd6:    p = 5'd13;
      4'd7:    p = 5'd17;
      4'd8:    p = 5'd19;
      4'd9:    p = 5'd23;
      default: p = 5'd1;
    endcase
    return p;
  endfunction

  // True when the controller state is one of the clearing states.
  function automatic logic is_clr_state(input logic [3:0] st);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CLR; i++) begin
      if (st == CLR_STATES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/answer_judge_bcd3_to_bin.sv
// Converts a 3-digit BCD number (hundreds, tens, ones) to binary and flags bad digits.
// Latency: combinational.
// Backpressure: none; output follows input.
module bcd3_to_bin (
  input  logic [11:0] bcd,
  output logic [9:0]  bin,
  output logic        digit_err
);

  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign ones     = bcd[3:0];

  // Weighted sum; value is meaningless when digit_err is set, so truncation there is harmless.
  always_comb begin
    bin = ({6'd0, hundreds} * 10'd100) + ({6'd0, tens} * 10'd10) + {6'd0, ones};
  end

  // Any nibble above 9 is not a decimal digit.
  always_comb begin
    digit_err = (hundreds > 4'd9) | (tens > 4'd9) | (ones > 4'd9);
  end

endmodule

// File: rtl/answer_judge.sv
// Judges the player's three factor codes: serial prime product compared with the BCD problem.
// Latency: DEC rising sampled at edge k -> RESULT/JUDGE_DONE updated at edge k+6.
// Backpressure: none; DEC while BUSY is dropped, leaving INPUT or a clearing state aborts.
module answer_judge
  import answer_judge_pkg::*;
#(
  parameter int PW = PW_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  STATE,
  input  logic [25:0] QUESTION,
  input  logic        DEC,
  input  logic [3:0]  COUNT1_IN,
  input  logic [3:0]  COUNT2_IN,
  input  logic [3:0]  COUNT3_IN,
  output logic [1:0]  RESULT,
  output logic        JUDGE_DONE,
  output logic        BUSY
);

  judge_state_t state_q;
  judge_state_t state_d;

  logic          dec_q;
  logic          dec_rise;
  logic          in_input;
  logic          clr_hit;

  logic          load_en;
  logic          mul_en;
  logic          cmp_en;
  logic [3:0]    mul_code;

  logic [3:0]    code1_q;
  logic [3:0]    code2_q;
  logic [3:0]    code3_q;
  logic [9:0]    problem_q;
  logic          invalid_q;
  logic [PW-1:0] product_q;

  logic [9:0]    problem_bin;
  logic          digit_err;
  logic          load_invalid;
  logic [4:0]    mul_prime;
  logic [PW-1:0] product_next;
  logic [1:0]    verdict;

  logic [1:0]    result_q;
  logic          done_q;

  // Difficulty and the low question bits carry nothing for judging.
  logic          unused_question_bits;
  assign unused_question_bits = ^{QUESTION[25:24], QUESTION[11:0]};

  assign in_input = (STATE == ST_INPUT);
  assign clr_hit  = is_clr_state(STATE);
  assign dec_rise = DEC & ~dec_q;

  bcd3_to_bin u_bcd (
    .bcd       (QUESTION[23:12]),
    .bin       (problem_bin),
    .digit_err (digit_err)
  );

  // Registers the decide level so a held button starts only one judgement.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= DEC;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= J_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes; abort and clear override the normal sequence.
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    mul_en   = 1'b0;
    cmp_en   = 1'b0;
    mul_code = 4'd0;
    case (state_q)
      J_IDLE: begin
        if (in_input && dec_rise && !clr_hit) state_d = J_WAIT;
      end
      J_WAIT: begin
        // Dead cycle: the input stage's committed codes settle here.
        state_d = J_LOAD;
      end
      J_LOAD: begin
        load_en = 1'b1;
        state_d = J_MUL1;
      end
      J_MUL1: begin
        mul_en   = 1'b1;
        mul_code = code1_q;
        state_d  = J_MUL2;
      end
      J_MUL2: begin
        mul_en   = 1'b1;
        mul_code = code2_q;
        state_d  = J_MUL3;
      end
      J_MUL3: begin
        mul_en   = 1'b1;
        mul_code = code3_q;
        state_d  = J_CMP;
      end
      J_CMP: begin
        cmp_en  = 1'b1;
        state_d = J_IDLE;
      end
      default: state_d = J_IDLE;
    endcase

    if ((state_q != J_IDLE) && (!in_input || clr_hit)) begin
      state_d = J_IDLE;
      load_en = 1'b0;
      mul_en  = 1'b0;
      cmp_en  = 1'b0;
    end
  end

  // Invalid if any slot code or problem digit is out of range.
  always_comb begin
    load_invalid = digit_err
                 | (COUNT1_IN > 4'd9)
                 | (COUNT2_IN > 4'd9)
                 | (COUNT3_IN > 4'd9);
  end

  // One serial multiply step; the product never exceeds 23^3 so PW bits do not wrap.
  always_comb begin
    mul_prime    = code_to_prime(mul_code);
    product_next = product_q * {{(PW-5){1'b0}}, mul_prime};
  end

  // Verdict; problems 0 and 1 cannot be written as a product of primes from the table.
  always_comb begin
    if (invalid_q) begin
      verdict = RES_INVALID;
    end else if ((product_q == {{(PW-10){1'b0}}, problem_q}) && (problem_q >= 10'd2)) begin
      verdict = RES_CORRECT;
    end else begin
      verdict = RES_WRONG;
    end
  end

  // Operand capture and running product.
  always_ff @(posedge CLK) begin
    if (RST) begin
      code1_q   <= 4'd0;
      code2_q   <= 4'd0;
      code3_q   <= 4'd0;
      problem_q <= 10'd0;
      invalid_q <= 1'b0;
      product_q <= '0;
    end else if (load_en) begin
      code1_q   <= COUNT1_IN;
      code2_q   <= COUNT2_IN;
      code3_q   <= COUNT3_IN;
      problem_q <= problem_bin;
      invalid_q <= load_invalid;
      product_q <= {{(PW-1){1'b0}}, 1'b1};
    end else if (mul_en) begin
      product_q <= product_next;
    end
  end

  // Result register: cleared by clearing states, loaded on compare, held otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q <= RES_NONE;
      done_q   <= 1'b0;
    end else begin
      done_q <= cmp_en;
      if (clr_hit) begin
        result_q <= RES_NONE;
      end else if (cmp_en) begin
        result_q <= verdict;
      end
    end
  end

  assign RESULT     = result_q;
  assign JUDGE_DONE = done_q;
  assign BUSY       = (state_q != J_IDLE);

endmodule
